// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: FSM states, owner
// encodings and default timing constants.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEF_MEM_LATENCY = 1;
    localparam int LAT_CNT_W       = 3;   // holds MEM_LATENCY-1 for latencies up to 7

endpackage

// File: rtl/unified_mem_arbiter_lat_counter.sv
// mem_lat_counter: loadable down-counter with a zero flag, used to time
// the fixed memory read latency.
module mem_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory port between
// instruction fetch (IF) and load/store (D). Data has priority unless the
// optional fairness streak limiter is built in with `define ARB_FAIRNESS_EN.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    // data requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    // Reject parameter values the counters cannot represent.
    if (MEM_LATENCY < 1 || MEM_LATENCY > 7 || MAX_D_STREAK < 1 || MAX_D_STREAK > 7) begin : g_param_check
        $error("unified_mem_arbiter: MEM_LATENCY and MAX_D_STREAK must be in 1..7");
    end

    arb_state_t        state_q;
    owner_t            owner_q;
    logic              is_store_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              if_valid_q;
    logic              d_valid_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_be_q;

    logic              grant_any_d;
    logic              grant_data_d;
    logic              force_if_d;
    logic              lat_zero;

`ifdef ARB_FAIRNESS_EN
    logic [2:0] streak_q;

    // A full data streak with fetch waiting hands the next grant to fetch.
    assign force_if_d = (streak_q == 3'(MAX_D_STREAK)) && if_req && d_req;

    // Count consecutive data grants made while fetch was kept waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= 3'd0;
        end else if ((state_q == ARB_IDLE) && grant_any_d) begin
            if (grant_data_d && if_req) begin
                streak_q <= streak_q + 3'd1;
            end else begin
                streak_q <= 3'd0;
            end
        end
    end
`else
    assign force_if_d = 1'b0;
`endif

    // Arbitration decision, evaluated only while the FSM is idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves it unassigned and a latch is inferred.
        grant_any_d  = 1'b0;
        grant_data_d = 1'b0;
        if (if_req || d_req) begin
            grant_any_d  = 1'b1;
            grant_data_d = d_req && !force_if_d;
        end
    end

    mem_lat_counter #(
        .W (LAT_CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ARB_ACCESS),
        .load_val_i (LAT_CNT_W'(MEM_LATENCY - 1)),
        .dec_i      ((state_q == ARB_WAIT) && !lat_zero),
        .zero_o     (lat_zero)
    );

    // Access sequencer: IDLE grants, ACCESS strobes, WAIT times the read,
    // RESP issues the completion pulse. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            is_store_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (grant_any_d) begin
                        mem_en_q <= 1'b1;
                        state_q  <= ARB_ACCESS;
                        if (grant_data_d) begin
                            owner_q     <= OWN_D;
                            is_store_q  <= d_we;
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            mem_be_q    <= d_be;
                        end else begin
                            owner_q     <= OWN_IF;
                            is_store_q  <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                            mem_be_q    <= '0;
                        end
                    end
                end
                ARB_ACCESS: begin
                    state_q <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (lat_zero) begin
                        state_q <= ARB_RESP;
                        if (owner_q == OWN_D) begin
                            d_valid_q <= 1'b1;
                            if (!is_store_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: begin   // ARB_RESP: request lines are stale here
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = (state_q != ARB_IDLE);

    // Stalls follow the request lines directly and ignore rst.
    assign if_stall = if_req & ~if_valid_q;
    assign d_stall  = d_req & ~d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter. Instance dut uses
// MEM_LATENCY=1, instance dut3 uses MEM_LATENCY=3 (fetch side only).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;

    logic        if_req;
    logic [5:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [5:0]  d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        busy;

    logic        f3_req;
    logic [5:0]  f3_addr;
    logic [31:0] f3_rdata;
    logic        f3_valid;
    logic        f3_stall;
    logic        z_req;
    logic        z_we;
    logic [5:0]  z_addr;
    logic [31:0] z_wdata;
    logic [3:0]  z_be;
    logic [31:0] d3_rdata;
    logic        d3_valid;
    logic        d3_stall;
    logic        m3_en;
    logic        m3_we;
    logic [5:0]  m3_addr;
    logic [31:0] m3_wdata;
    logic [3:0]  m3_be;
    logic [31:0] m3_rdata;
    logic        busy3;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [64];
    logic [31:0] rd1;
    logic [31:0] p3 [3];

    unified_mem_arbiter #(.ADDR_W(6), .MEM_LATENCY(1), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    unified_mem_arbiter #(.ADDR_W(6), .MEM_LATENCY(3), .MAX_D_STREAK(4)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(f3_req), .if_addr(f3_addr), .if_rdata(f3_rdata), .if_valid(f3_valid), .if_stall(f3_stall),
        .d_req(z_req), .d_we(z_we), .d_addr(z_addr), .d_wdata(z_wdata), .d_be(z_be),
        .d_rdata(d3_rdata), .d_valid(d3_valid), .d_stall(d3_stall),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_be(m3_be),
        .mem_rdata(m3_rdata), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency-1 memory: read data appears the cycle after mem_en is sampled.
    always @(posedge clk) begin
        if (mem_en) begin
            rd1 <= mem[mem_addr];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end
    assign mem_rdata = rd1;

    // Latency-3 memory (read-only) for dut3.
    always @(posedge clk) begin
        if (m3_en) p3[0] <= mem[m3_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m3_rdata = p3[2];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        if_req = 1'b1;
        if_addr = 6'd3;
        #1;
        checks++;
        if (if_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_ungated got=%b exp=1", if_stall); end
        tick();
        if_req = 1'b0;
        checks++;
        if ({busy, mem_en, mem_we, if_valid, d_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, mem_en, mem_we, if_valid, d_valid});
        end
        checks++;
        if ({if_rdata, d_rdata} !== 64'd0) begin
            errors++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, d_rdata});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_be} !== 42'd0) begin
            errors++; $display("FAIL reset_mem_fields got=%h exp=0", {mem_addr, mem_wdata, mem_be});
        end
        checks++;
        if ({busy3, m3_en, f3_valid} !== 3'b0) begin
            errors++; $display("FAIL reset_dut3 got=%b exp=000", {busy3, m3_en, f3_valid});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 6'd3;                          // t0
        #1;
        checks++;
        if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_t0 got=%b exp=1", if_stall); end
        tick();                                                  // t0+1
        checks++;
        if ({mem_en, mem_we, mem_addr, busy, if_stall} !== {1'b1, 1'b0, 6'd3, 1'b1, 1'b1}) begin
            errors++; $display("FAIL fetch_access got=%h exp=%h", {mem_en, mem_we, mem_addr, busy, if_stall}, {1'b1, 1'b0, 6'd3, 1'b1, 1'b1});
        end
        tick();                                                  // t0+2
        checks++;
        if ({mem_en, if_valid, if_stall} !== 3'b001) begin
            errors++; $display("FAIL fetch_wait got=%b exp=001", {mem_en, if_valid, if_stall});
        end
        tick();                                                  // t0+3
        checks++;
        if ({if_valid, if_stall, if_rdata} !== {1'b1, 1'b0, 32'h06448313}) begin
            errors++; $display("FAIL fetch_resp valid/stall/rdata got=%b/%b/%h exp=1/0/06448313", if_valid, if_stall, if_rdata);
        end
        if_req = 1'b0;
        tick();                                                  // t0+4
        checks++;
        if ({if_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL fetch_pulse_end got=%b exp=00", {if_valid, busy});
        end
    endtask

    task automatic test_collision();
        if_req = 1'b1; if_addr = 6'd3;                          // t0
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd5;
        tick();                                                  // t0+1
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 6'd5}) begin
            errors++; $display("FAIL coll_data_first got=%h exp=%h", {mem_en, mem_addr}, {1'b1, 6'd5});
        end
        tick();                                                  // t0+2
        tick();                                                  // t0+3
        checks++;
        if ({d_valid, if_valid, if_stall, d_rdata} !== {1'b1, 1'b0, 1'b1, 32'd6}) begin
            errors++; $display("FAIL coll_load_resp dv/iv/is/rdata got=%b/%b/%b/%h exp=1/0/1/6", d_valid, if_valid, if_stall, d_rdata);
        end
        d_req = 1'b0;
        tick();                                                  // t0+4
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL coll_idle_gap got=%b exp=0", mem_en); end
        tick();                                                  // t0+5
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 6'd3}) begin
            errors++; $display("FAIL coll_fetch_access got=%h exp=%h", {mem_en, mem_addr}, {1'b1, 6'd3});
        end
        tick();                                                  // t0+6
        checks++;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL coll_fetch_early got=%b exp=0", if_valid); end
        tick();                                                  // t0+7
        checks++;
        if ({if_valid, if_rdata} !== {1'b1, 32'h06448313}) begin
            errors++; $display("FAIL coll_fetch_resp got=%b/%h exp=1/06448313", if_valid, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd10;             // t0
        d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        tick();                                                  // t0+1
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 6'd10, 32'hDEADBEEF, 4'b0011}) begin
            errors++; $display("FAIL store_fields got=%h exp=%h", {mem_en, mem_we, mem_addr, mem_wdata, mem_be},
                               {1'b1, 1'b1, 6'd10, 32'hDEADBEEF, 4'b0011});
        end
        tick();                                                  // t0+2
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b0, 1'b0, 6'd10}) begin
            errors++; $display("FAIL store_single_strobe got=%h exp=%h", {mem_en, mem_we, mem_addr}, {1'b0, 1'b0, 6'd10});
        end
        tick();                                                  // t0+3
        checks++;
        if ({d_valid, d_rdata} !== {1'b1, 32'd6}) begin
            errors++; $display("FAIL store_resp valid/rdata got=%b/%h exp=1/00000006", d_valid, d_rdata);
        end
        d_we = 1'b0;                                             // reload the same word
        tick();                                                  // t0+4
        tick();
        tick();
        tick();                                                  // t0+7
        checks++;
        if ({d_valid, d_rdata} !== {1'b1, 32'h0000BEEF}) begin
            errors++; $display("FAIL store_readback got=%b/%h exp=1/0000beef", d_valid, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_latency3();
        f3_req = 1'b1; f3_addr = 6'd7;                          // t0
        #1;
        checks++;
        if (busy3 !== 1'b0) begin errors++; $display("FAIL lat3_busy_t0 got=%b exp=0", busy3); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if ({busy3, m3_en, f3_valid} !== {(k <= 5), (k == 1), (k == 5)}) begin
                errors++; $display("FAIL lat3_t%0d busy/en/valid got=%b exp=%b", k, {busy3, m3_en, f3_valid},
                                   {(k <= 5), (k == 1), (k == 5)});
            end
            if (k == 5) begin
                checks++;
                if (f3_rdata !== 32'h11223344) begin errors++; $display("FAIL lat3_rdata got=%h exp=11223344", f3_rdata); end
                f3_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        if_req = 1'b1; if_addr = 6'd3;                          // t0
        tick();                                                  // t0+1 ACCESS
        tick();                                                  // t0+2 WAIT
        rst = 1'b1;
        #1;
        checks++;
        if (if_stall !== 1'b1) begin errors++; $display("FAIL rstwait_stall got=%b exp=1", if_stall); end
        tick();                                                  // t0+3
        checks++;
        if ({if_valid, busy, mem_en, mem_we, if_rdata, mem_addr} !== 42'd0) begin
            errors++; $display("FAIL rstwait_outputs got=%h exp=0", {if_valid, busy, mem_en, mem_we, if_rdata, mem_addr});
        end
        rst = 1'b0;
        tick();                                                  // t0+4
        checks++;
        if ({mem_en, mem_addr} !== {1'b1, 6'd3}) begin
            errors++; $display("FAIL rstwait_restart got=%h exp=%h", {mem_en, mem_addr}, {1'b1, 6'd3});
        end
        tick();
        tick();                                                  // t0+6
        checks++;
        if ({if_valid, if_rdata} !== {1'b1, 32'h06448313}) begin
            errors++; $display("FAIL rstwait_resp got=%b/%h exp=1/06448313", if_valid, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        logic [5:0] grants [12];
        logic [5:0] exp_addr;
        int n = 0;
        bit idle = 1'b0;
        if_req = 1'b1; if_addr = 6'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd5;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (mem_en === 1'b1 && n < 12) begin
                grants[n] = mem_addr;
                n++;
            end
        end
        if_req = 1'b0;
        d_req = 1'b0;
        checks++;
        if (n != 10) begin errors++; $display("FAIL fair_grant_count got=%0d exp=10", n); end
        for (int i = 0; i < 10 && i < n; i++) begin
`ifdef ARB_FAIRNESS_EN
            exp_addr = ((i % 5) == 4) ? 6'd3 : 6'd5;
`else
            exp_addr = 6'd5;
`endif
            checks++;
            if (grants[i] !== exp_addr) begin
                errors++; $display("FAIL fair_grant_%0d got=%0d exp=%0d", i, grants[i], exp_addr);
            end
        end
        for (int c = 0; c < 20 && !idle; c++) begin
            tick();
            idle = (busy === 1'b0) && (busy3 === 1'b0);
        end
        checks++;
        if (!idle) begin errors++; $display("FAIL fair_drain got busy=%b exp=0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        f3_req = 1'b0; f3_addr = '0;
        z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[3] = 32'h06448313;
        mem[5] = 32'd6;
        mem[7] = 32'h11223344;

        test_reset();
        test_fetch();
        test_collision();
        test_store();
        test_latency3();
        test_reset_mid_wait();
        test_fairness();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
